controlador_sequenciador: RTL

//  Control unit of the SAP-1 datapath: a 6-state one-hot ring counter (T1..T6) plus an instruction decoder.

---
 rtl/controlador_sequenciador.sv | 91 +++++++++
 1 files changed

// File: rtl/controlador_sequenciador.sv
// controlador_sequenciador: SAP-1 control unit, one-hot T1..T6 ring counter plus LDA/ADD/SUB/OUT/HLT decoder
module controlador_sequenciador #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       Cp,
    output logic       Ep,
    output logic       Lm,
    output logic       Ce,
    output logic       Li,
    output logic       Ei,
    output logic       La,
    output logic       Ea,
    output logic       Su,
    output logic       Eu,
    output logic       Lb,
    output logic       Lo,
    output logic       HLT
);
    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } state_t;

    state_t state, state_n;
    logic   halted, halted_n;
    logic   mem_op, alu_op, is_lda, is_sub, is_out;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state  <= T1;
            halted <= 1'b0;
        end else begin
            state  <= state_n;
            halted <= halted_n;
        end
    end

    // HLT freezes the ring in T4 instead of advancing to T5
    always_comb begin
        state_n  = state;
        halted_n = halted;
        if (!halted) begin
            if (state == T4 && opcode == OP_HLT) halted_n = 1'b1;
            else begin
                case (state)
                    T1:      state_n = T2;
                    T2:      state_n = T3;
                    T3:      state_n = T4;
                    T4:      state_n = T5;
                    T5:      state_n = T6;
                    default: state_n = T1;
                endcase
            end
        end
    end

    always_comb begin
        is_lda = opcode == OP_LDA;
        is_sub = opcode == OP_SUB;
        is_out = opcode == OP_OUT;
        alu_op = opcode == OP_ADD || is_sub;
        mem_op = is_lda || alu_op;
        Ep  = !halted && state == T1;
        Cp  = !halted && state == T2;
        Li  = !halted && state == T3;
        Lm  = !halted && (state == T1 || (state == T4 && mem_op));
        Ei  = !halted && state == T4 && mem_op;
        Ea  = !halted && state == T4 && is_out;
        Lo  = !halted && state == T4 && is_out;
        Ce  = !halted && (state == T3 || (state == T5 && mem_op));
        Lb  = !halted && state == T5 && alu_op;
        La  = !halted && ((state == T5 && is_lda) || (state == T6 && alu_op));
        Eu  = !halted && state == T6 && alu_op;
        Su  = !halted && state == T6 && is_sub;
        HLT = halted;
    end

    assign t_state = state;
endmodule
